// File: rtl/speed_pkg.sv
// Shared constants and helpers for the speed-level controller.
// The tick period shrinks linearly with the level.
package speed_pkg;

   localparam int MODE_WRAP = 1;
   localparam int MODE_SAT  = 0;

   function automatic int unsigned period_of(input int unsigned base,
                                             input int unsigned step,
                                             input int unsigned lvl);
      return base - lvl * step;
   endfunction

   function automatic int cnt_width(input int unsigned base);
      return $clog2(base + 1);
   endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Raw push-button to step pulse: 2-FF sync, debounce, rising-edge detect
// and optional auto-repeat while held.
module btn_conditioner
   import speed_pkg::*;
#(
   parameter int DEB_CYCLES   = 500000,
   parameter int REPEAT_EN    = 1,
   parameter int REPEAT_DELAY = 25000000,
   parameter int REPEAT_RATE  = 5000000
)(
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic step
);

   localparam int DEB_W   = $clog2(DEB_CYCLES + 1);
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int REP_W   = $clog2(REP_MAX + 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
   localparam logic [REP_W-1:0] DELAY_V  = REP_W'(REPEAT_DELAY);
   localparam logic [REP_W-1:0] RATE_V   = REP_W'(REPEAT_RATE);

   logic             sync_a;
   logic             sync_b;
   logic             deb;
   logic             deb_prev;
   logic [DEB_W-1:0] deb_cnt;
   logic [REP_W-1:0] rep_cnt;
   logic             rep_phase;
   logic             rise;
   logic             rep_fire;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_a   <= 1'b0;
         sync_b   <= 1'b0;
         deb      <= 1'b0;
         deb_prev <= 1'b0;
         deb_cnt  <= '0;
      end else begin
         sync_a   <= btn_raw;
         sync_b   <= sync_a;
         deb_prev <= deb;
         if (sync_b == deb) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_LAST) begin
            deb     <= ~deb;
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
         end
      end
   end

   assign rise = deb & ~deb_prev;

   // rep_cnt counts held cycles including the press cycle, so the first
   // repeat lands REPEAT_DELAY cycles after the initial step.
   assign rep_fire = (REPEAT_EN != 0) && deb &&
                     (rep_cnt == (rep_phase ? RATE_V : DELAY_V));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rep_cnt   <= '0;
         rep_phase <= 1'b0;
         step      <= 1'b0;
      end else begin
         step <= rise | rep_fire;
         if (!deb || (REPEAT_EN == 0)) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
         end else if (rep_fire) begin
            rep_cnt   <= REP_W'(1);
            rep_phase <= 1'b1;
         end else begin
            rep_cnt <= rep_cnt + REP_W'(1);
         end
      end
   end

endmodule

// File: rtl/speed_level_ctrl.sv
// Speed-level controller: two conditioned buttons step a level register,
// which sets the period of the move_tick pulse generator.
module speed_level_ctrl
   import speed_pkg::*;
#(
   parameter int NUM_LEVELS   = 5,
   parameter int LVL_W        = 3,
   parameter int DEB_CYCLES   = 500000,
   parameter int WRAP         = 1,
   parameter int RESET_LEVEL  = 0,
   parameter int REPEAT_EN    = 1,
   parameter int REPEAT_DELAY = 25000000,
   parameter int REPEAT_RATE  = 5000000,
   parameter int BASE_PERIOD  = 50000000,
   parameter int PERIOD_STEP  = 10000000
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             btn_up,
   input  logic             btn_dn,
   output logic [LVL_W-1:0] level,
   output logic             at_max,
   output logic             at_min,
   output logic             lvl_chg,
   output logic             move_tick
);

   localparam int CNT_W = cnt_width(BASE_PERIOD);
   localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(NUM_LEVELS - 1);
   localparam logic [LVL_W-1:0] LVL_RST = LVL_W'(RESET_LEVEL);

   logic             step_up;
   logic             step_dn;
   logic [LVL_W-1:0] level_nxt;
   logic             changed;
   logic [CNT_W-1:0] tick_cnt;
   logic [CNT_W-1:0] tick_last;

   btn_conditioner #(
      .DEB_CYCLES  (DEB_CYCLES),
      .REPEAT_EN   (REPEAT_EN),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
   ) u_up (
      .clk    (clk),
      .rst    (rst),
      .btn_raw(btn_up),
      .step   (step_up)
   );

   btn_conditioner #(
      .DEB_CYCLES  (DEB_CYCLES),
      .REPEAT_EN   (REPEAT_EN),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
   ) u_dn (
      .clk    (clk),
      .rst    (rst),
      .btn_raw(btn_dn),
      .step   (step_dn)
   );

   always_comb begin
      level_nxt = level;
      if (step_up && !step_dn) begin
         if (level == LVL_MAX) level_nxt = (WRAP == MODE_WRAP) ? '0 : level;
         else                  level_nxt = level + LVL_W'(1);
      end else if (step_dn && !step_up) begin
         if (level == '0) level_nxt = (WRAP == MODE_WRAP) ? LVL_MAX : level;
         else             level_nxt = level - LVL_W'(1);
      end
   end

   assign changed   = (level_nxt != level);
   assign tick_last = CNT_W'(period_of(BASE_PERIOD, PERIOD_STEP, 32'(level)) - 32'd1);

   // A level change restarts the period so the next tick is a full new period away.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level     <= LVL_RST;
         lvl_chg   <= 1'b0;
         tick_cnt  <= '0;
         move_tick <= 1'b0;
      end else begin
         level   <= level_nxt;
         lvl_chg <= changed;
         if (changed) begin
            tick_cnt  <= '0;
            move_tick <= 1'b0;
         end else if (tick_cnt == tick_last) begin
            tick_cnt  <= '0;
            move_tick <= 1'b1;
         end else begin
            tick_cnt  <= tick_cnt + CNT_W'(1);
            move_tick <= 1'b0;
         end
      end
   end

   assign at_max = (level == LVL_MAX);
   assign at_min = (level == '0);

endmodule

// File: tb/tb_speed_level_ctrl.sv
// Directed bench for speed_level_ctrl: three instances cover wrap, saturate
// and auto-repeat configurations with shared clock and reset.
module tb_speed_level_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       w_up = 1'b0, w_dn = 1'b0;
   logic       s_up = 1'b0, s_dn = 1'b0;
   logic       r_up = 1'b0, r_dn = 1'b0;
   logic [2:0] w_level, s_level, r_level;
   logic       w_max, w_min, w_chg, w_tick;
   logic       s_max, s_min, s_chg, s_tick;
   logic       r_max, r_min, r_chg, r_tick;

   int total = 0;
   int bad   = 0;
   int w_cnt = 0;
   int s_cnt = 0;
   int r_cnt = 0;

   always #5 clk = ~clk;

   speed_level_ctrl #(.NUM_LEVELS(5), .LVL_W(3), .DEB_CYCLES(4), .WRAP(1), .RESET_LEVEL(0),
      .REPEAT_EN(0), .REPEAT_DELAY(20), .REPEAT_RATE(5), .BASE_PERIOD(20), .PERIOD_STEP(4))
   dut_w (.clk(clk), .rst(rst), .btn_up(w_up), .btn_dn(w_dn), .level(w_level),
      .at_max(w_max), .at_min(w_min), .lvl_chg(w_chg), .move_tick(w_tick));

   speed_level_ctrl #(.NUM_LEVELS(5), .LVL_W(3), .DEB_CYCLES(4), .WRAP(0), .RESET_LEVEL(0),
      .REPEAT_EN(0), .REPEAT_DELAY(20), .REPEAT_RATE(5), .BASE_PERIOD(20), .PERIOD_STEP(4))
   dut_s (.clk(clk), .rst(rst), .btn_up(s_up), .btn_dn(s_dn), .level(s_level),
      .at_max(s_max), .at_min(s_min), .lvl_chg(s_chg), .move_tick(s_tick));

   speed_level_ctrl #(.NUM_LEVELS(5), .LVL_W(3), .DEB_CYCLES(4), .WRAP(1), .RESET_LEVEL(0),
      .REPEAT_EN(1), .REPEAT_DELAY(20), .REPEAT_RATE(5), .BASE_PERIOD(20), .PERIOD_STEP(4))
   dut_r (.clk(clk), .rst(rst), .btn_up(r_up), .btn_dn(r_dn), .level(r_level),
      .at_max(r_max), .at_min(r_min), .lvl_chg(r_chg), .move_tick(r_tick));

   always @(negedge clk) begin
      if (w_chg) w_cnt++;
      if (s_chg) s_cnt++;
      if (r_chg) r_cnt++;
   end

   task automatic step_clk(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Cycles until the wrap instance pulses move_tick, capped at 100.
   task automatic gap_to_tick(output int n);
      n = 0;
      do begin
         step_clk(1);
         n++;
      end while (!w_tick && n < 100);
   endtask

   // d: 0 = wrap instance, 1 = saturate instance; up selects the button.
   task automatic press(input int d, input bit up);
      if (d == 0) begin if (up) w_up = 1'b1; else w_dn = 1'b1; end
      else        begin if (up) s_up = 1'b1; else s_dn = 1'b1; end
      step_clk(10);
      w_up = 1'b0; w_dn = 1'b0; s_up = 1'b0; s_dn = 1'b0;
      step_clk(12);
   endtask

   initial begin
      int n;
      int c0;

      // reset state
      step_clk(2);
      check_val("rst_level", w_level, 0);
      check_val("rst_chg", w_chg, 0);
      check_val("rst_tick", w_tick, 0);
      check_val("rst_min", w_min, 1);
      check_val("rst_max", w_max, 0);
      rst = 1'b0;

      // level-0 tick period
      gap_to_tick(n);
      check_val("tick_l0_first", n, 20);
      gap_to_tick(n);
      check_val("tick_l0_next", n, 20);

      // bouncing button then a clean hold: exactly one step
      c0 = w_cnt;
      for (int i = 0; i < 10; i++) begin
         w_up = (i % 2 == 0);
         step_clk(2);
      end
      check_val("bounce_nostep", w_level, 0);
      w_up = 1'b1;
      step_clk(10);
      w_up = 1'b0;
      step_clk(12);
      check_val("bounce_level", w_level, 1);
      check_val("bounce_chg_cnt", w_cnt - c0, 1);

      // latency: level visible after edge k+7
      w_up = 1'b1;
      step_clk(7);
      check_val("lat_early", w_level, 1);
      check_val("lat_early_chg", w_chg, 0);
      step_clk(1);
      check_val("lat_level", w_level, 2);
      check_val("lat_chg", w_chg, 1);
      w_up = 1'b0;
      gap_to_tick(n);
      check_val("tick_l2_first", n, 12);
      gap_to_tick(n);
      check_val("tick_l2_next", n, 12);
      step_clk(5);

      // wrap mode
      press(0, 1'b1);
      check_val("wrap_l3", w_level, 3);
      press(0, 1'b1);
      check_val("wrap_l4", w_level, 4);
      check_val("wrap_max", w_max, 1);
      c0 = w_cnt;
      press(0, 1'b1);
      check_val("wrap_l0", w_level, 0);
      check_val("wrap_min", w_min, 1);
      check_val("wrap_chg", w_cnt - c0, 1);
      press(0, 1'b0);
      check_val("wrap_dn_l4", w_level, 4);

      // simultaneous press cancels
      c0 = w_cnt;
      w_up = 1'b1;
      w_dn = 1'b1;
      step_clk(12);
      check_val("simul_level", w_level, 4);
      w_dn = 1'b0;
      step_clk(12);
      w_up = 1'b0;
      step_clk(12);
      check_val("simul_hold", w_level, 4);
      check_val("simul_chg_cnt", w_cnt - c0, 0);
      c0 = w_cnt;
      press(0, 1'b1);
      check_val("simul_repress", w_level, 0);
      check_val("simul_repress_chg", w_cnt - c0, 1);

      // saturate mode
      for (int i = 0; i < 6; i++) begin
         c0 = s_cnt;
         press(1, 1'b1);
         check_val($sformatf("sat_up%0d", i), s_level, (i < 4) ? i + 1 : 4);
         if (i == 5) check_val("sat_no_chg", s_cnt - c0, 0);
      end
      check_val("sat_max", s_max, 1);
      press(1, 1'b0);
      check_val("sat_dn", s_level, 3);

      // auto-repeat: offsets from the first change
      r_up = 1'b1;
      step_clk(8);
      check_val("rep_first_chg", r_chg, 1);
      check_val("rep_first_lvl", r_level, 1);
      for (int o = 1; o <= 62; o++) begin
         step_clk(1);
         check_val($sformatf("rep_o%0d", o), r_chg, (o >= 20 && (o - 20) % 5 == 0) ? 1 : 0);
      end
      r_up = 1'b0;
      step_clk(20);
      c0 = r_cnt;
      step_clk(30);
      check_val("rep_release", r_cnt - c0, 0);

      // asynchronous reset mid-operation while move_tick is high
      press(0, 1'b1);
      check_val("pre_rst_level", w_level, 1);
      n = 0;
      while (!w_tick && n < 100) begin
         step_clk(1);
         n++;
      end
      check_val("pre_rst_tick", w_tick, 1);
      #2 rst = 1'b1;
      #1;
      check_val("async_rst_level", w_level, 0);
      check_val("async_rst_tick", w_tick, 0);

      // button held through reset deassertion must fully debounce
      w_up = 1'b1;
      step_clk(3);
      rst = 1'b0;
      step_clk(7);
      check_val("held_rst_early", w_level, 0);
      step_clk(1);
      check_val("held_rst_level", w_level, 1);
      w_up = 1'b0;
      step_clk(12);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
